// File: rtl/kbd_pkg.sv
// kbd_pkg: shared types and constants for the PS/2 Set-2 movement-key decoder.
//   kbd_state_t       : decoder FSM states
//   KBD_* constants   : protocol prefix/status bytes and extended arrow codes
//   KEY_*_BIT         : bit positions of W/A/D inside the 3-bit held-key vectors
//   kbd_arrow_map()   : one-hot held-key vector for an extended arrow code
package kbd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BRK,
    EXT,
    EXT_BRK
  } kbd_state_t;

  localparam logic [7:0] KBD_BREAK  = 8'hF0;
  localparam logic [7:0] KBD_EXT    = 8'hE0;
  localparam logic [7:0] KBD_BAT_OK = 8'hAA;
  localparam logic [7:0] KBD_ERR_FF = 8'hFF;
  localparam logic [7:0] KBD_ERR_00 = 8'h00;

  localparam logic [7:0] KBD_UP    = 8'h75;
  localparam logic [7:0] KBD_LEFT  = 8'h6B;
  localparam logic [7:0] KBD_RIGHT = 8'h74;

  localparam int unsigned KEY_W_BIT = 0;
  localparam int unsigned KEY_A_BIT = 1;
  localparam int unsigned KEY_D_BIT = 2;

  function automatic logic [2:0] kbd_arrow_map(input logic [7:0] code);
    logic [2:0] hit;
    hit = '0;
    case (code)
      KBD_UP:    hit[KEY_W_BIT] = 1'b1;
      KBD_LEFT:  hit[KEY_A_BIT] = 1'b1;
      KBD_RIGHT: hit[KEY_D_BIT] = 1'b1;
      default:   hit = '0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/kbd_prefix_watchdog.sv
// kbd_prefix_watchdog: bounds how long a pending scancode prefix may wait.
//   clk_i    : system clock
//   rst_i    : synchronous active-high reset
//   run_i    : 1 while the decoder is waiting after a prefix byte
//   clear_i  : 1 when a byte is being processed (restarts the count)
//   expire_o : combinational, 1 in the cycle the wait limit is hit with no byte
// Counter is $clog2(TIMEOUT) bits and saturates at TIMEOUT-1.
module kbd_prefix_watchdog #(
  parameter int unsigned TIMEOUT = 65_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  input  logic clear_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || !run_i) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A byte in the expiry cycle takes priority, so clear_i masks expiry.
  assign expire_o = run_i && !clear_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/kbd_move_decoder.sv
// kbd_move_decoder: turns PS/2 Set-2 scancode bytes into level-held W/A/D
// movement key signals, tracking make/break (F0) and extended (E0) prefixes.
//   clk      : system clock
//   rst      : synchronous active-high reset
//   rx_data  : received scancode byte, valid with rx_valid
//   rx_valid : one-cycle strobe per received byte
//   key_w/a/d: 1 while the corresponding key is held
//   rx_err   : one-cycle pulse on protocol error, FF/00 status, or prefix timeout
// Optional build macro KBD_ARROW_KEYS_EN: E0-prefixed Up/Left/Right arrows are
// tracked as separate held bits and ORed onto key_w/key_a/key_d.
module kbd_move_decoder
  import kbd_pkg::*;
#(
  parameter logic [7:0]  CODE_W         = 8'h1D,
  parameter logic [7:0]  CODE_A         = 8'h1C,
  parameter logic [7:0]  CODE_D         = 8'h23,
  parameter int unsigned PREFIX_TIMEOUT = 65_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       key_w,
  output logic       key_a,
  output logic       key_d,
  output logic       rx_err
);

  // Incoming bytes are captured first and decoded one cycle later, so a byte
  // strobed at edge N shows on the outputs at edge N+1.
  logic [7:0] byte_q;
  logic       vld_q;

  kbd_state_t state_q, state_d;
  logic [2:0] letter_q, letter_d;
  logic       err_q, err_d;
  logic [2:0] letter_hit;
  logic       status_byte;
  logic       expire;

`ifdef KBD_ARROW_KEYS_EN
  logic [2:0] arrow_q, arrow_d;
  logic [2:0] arrow_hit;
  logic [2:0] key_q;
  assign arrow_hit = kbd_arrow_map(byte_q);
`endif

  always_comb begin
    letter_hit            = '0;
    letter_hit[KEY_W_BIT] = (byte_q == CODE_W);
    letter_hit[KEY_A_BIT] = (byte_q == CODE_A);
    letter_hit[KEY_D_BIT] = (byte_q == CODE_D);
  end

  assign status_byte = (byte_q == KBD_ERR_FF) || (byte_q == KBD_ERR_00) ||
                       (byte_q == KBD_BAT_OK);

  kbd_prefix_watchdog #(
    .TIMEOUT(PREFIX_TIMEOUT)
  ) u_watchdog (
    .clk_i   (clk),
    .rst_i   (rst),
    .run_i   (state_q != IDLE),
    .clear_i (vld_q),
    .expire_o(expire)
  );

  always_comb begin
    state_d  = state_q;
    letter_d = letter_q;
    err_d    = 1'b0;
`ifdef KBD_ARROW_KEYS_EN
    arrow_d  = arrow_q;
`endif
    if (vld_q) begin
      if (status_byte) begin
        state_d  = IDLE;
        letter_d = '0;
        err_d    = (byte_q != KBD_BAT_OK);
`ifdef KBD_ARROW_KEYS_EN
        arrow_d  = '0;
`endif
      end else begin
        unique case (state_q)
          IDLE: begin
            if (byte_q == KBD_BREAK) begin
              state_d = BRK;
            end else if (byte_q == KBD_EXT) begin
              state_d = EXT;
            end else begin
              letter_d = letter_q | letter_hit;
            end
          end
          BRK: begin
            state_d = IDLE;
            if (byte_q == KBD_BREAK || byte_q == KBD_EXT) begin
              err_d = 1'b1;
            end else begin
              letter_d = letter_q & ~letter_hit;
            end
          end
          EXT: begin
            if (byte_q == KBD_BREAK) begin
              state_d = EXT_BRK;
            end else begin
              state_d = IDLE;
`ifdef KBD_ARROW_KEYS_EN
              arrow_d = arrow_q | arrow_hit;
`endif
            end
          end
          EXT_BRK: begin
            state_d = IDLE;
`ifdef KBD_ARROW_KEYS_EN
            arrow_d = arrow_q & ~arrow_hit;
`endif
          end
          default: state_d = IDLE;
        endcase
      end
    end else if (expire) begin
      // A lost break byte must not leave a key stuck, so drop everything.
      state_d  = IDLE;
      letter_d = '0;
      err_d    = 1'b1;
`ifdef KBD_ARROW_KEYS_EN
      arrow_d  = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_q   <= '0;
      vld_q    <= 1'b0;
      state_q  <= IDLE;
      letter_q <= '0;
      err_q    <= 1'b0;
`ifdef KBD_ARROW_KEYS_EN
      arrow_q  <= '0;
      key_q    <= '0;
`endif
    end else begin
      byte_q   <= rx_data;
      vld_q    <= rx_valid;
      state_q  <= state_d;
      letter_q <= letter_d;
      err_q    <= err_d;
`ifdef KBD_ARROW_KEYS_EN
      arrow_q  <= arrow_d;
      key_q    <= letter_d | arrow_d;
`endif
    end
  end

`ifdef KBD_ARROW_KEYS_EN
  assign key_w = key_q[KEY_W_BIT];
  assign key_a = key_q[KEY_A_BIT];
  assign key_d = key_q[KEY_D_BIT];
`else
  assign key_w = letter_q[KEY_W_BIT];
  assign key_a = letter_q[KEY_A_BIT];
  assign key_d = letter_q[KEY_D_BIT];
`endif
  assign rx_err = err_q;

endmodule

// File: tb/tb_kbd_move_decoder.sv
// tb_kbd_move_decoder: directed-vector bench for kbd_move_decoder with a short
// prefix timeout. Inputs change on the falling edge; outputs are sampled there.
module tb_kbd_move_decoder;

  localparam int unsigned TMO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       key_w, key_a, key_d, rx_err;

  int n_checks = 0;
  int n_errors = 0;
  int err_seen = 0;
  int err_mark;

  kbd_move_decoder #(
    .CODE_W        (8'h1D),
    .CODE_A        (8'h1C),
    .CODE_D        (8'h23),
    .PREFIX_TIMEOUT(TMO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .key_w   (key_w),
    .key_a   (key_a),
    .key_d   (key_d),
    .rx_err  (rx_err)
  );

  always #5 clk = ~clk;

  // Counts cycles in which rx_err is high, to check pulse counts.
  always @(negedge clk) begin
    if (rx_err === 1'b1) err_seen <= err_seen + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Presents one byte for exactly one rising edge; returns on the next falling edge.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h5A;
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tick(3);
    check("reset_keys", {29'd0, key_w, key_a, key_d}, 32'd0);
    check("reset_err", {31'd0, rx_err}, 32'd0);
    rst = 1'b0;
    tick(2);

    // Make / break of W, 100 cycles apart
    err_mark = err_seen;
    send(8'h1D);
    check("w_make_latency", {31'd0, key_w}, 32'd0);
    tick();
    check("w_make", {31'd0, key_w}, 32'd1);
    tick(100);
    check("w_held", {31'd0, key_w}, 32'd1);
    send(8'hF0);
    send(8'h1D);
    check("w_break_latency", {31'd0, key_w}, 32'd1);
    tick();
    check("w_break", {31'd0, key_w}, 32'd0);
    check("mb_no_err", err_seen - err_mark, 32'd0);

    // Multiple keys, break of one, typematic repeats of the other
    send(8'h1C);
    send(8'h23);
    tick();
    check("multi_a", {31'd0, key_a}, 32'd1);
    check("multi_d", {31'd0, key_d}, 32'd1);
    send(8'hF0);
    send(8'h1C);
    tick();
    check("multi_a_brk", {31'd0, key_a}, 32'd0);
    check("multi_d_kept", {31'd0, key_d}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      send(8'h23);
      check("typematic_d", {31'd0, key_d}, 32'd1);
    end
    send(8'hF0);
    send(8'h23);
    tick();
    check("d_break", {31'd0, key_d}, 32'd0);
    send(8'hF0);
    send(8'h23);
    tick();
    check("d_break_again", {31'd0, key_d}, 32'd0);

    // Watchdog expiry after a lone F0
    send(8'h1D);
    tick();
    err_mark = err_seen;
    send(8'hF0);
    tick(TMO);
    check("wd_before_w", {31'd0, key_w}, 32'd1);
    check("wd_before_err", {31'd0, rx_err}, 32'd0);
    tick();
    check("wd_expire_w", {31'd0, key_w}, 32'd0);
    check("wd_expire_err", {31'd0, rx_err}, 32'd1);
    tick();
    check("wd_err_pulse", {31'd0, rx_err}, 32'd0);
    check("wd_err_count", err_seen - err_mark, 32'd1);
    send(8'h1D);
    tick();
    check("wd_remake_w", {31'd0, key_w}, 32'd1);

    // Byte arriving in the expiry cycle wins
    err_mark = err_seen;
    send(8'hF0);
    tick(TMO - 1);
    send(8'h1D);
    tick();
    check("race_break_w", {31'd0, key_w}, 32'd0);
    tick(TMO + 4);
    check("race_no_err", err_seen - err_mark, 32'd0);

    // Overrun FF clears all keys with one error pulse
    err_mark = err_seen;
    send(8'h1C);
    send(8'h23);
    send(8'hFF);
    tick();
    check("ff_keys", {29'd0, key_w, key_a, key_d}, 32'd0);
    check("ff_err", {31'd0, rx_err}, 32'd1);
    tick();
    check("ff_err_count", err_seen - err_mark, 32'd1);

    // Error code 00 from inside a prefix
    err_mark = err_seen;
    send(8'h1D);
    send(8'hE0);
    send(8'h00);
    tick(2);
    check("00_keys", {29'd0, key_w, key_a, key_d}, 32'd0);
    check("00_err_count", err_seen - err_mark, 32'd1);

    // BAT OK clears keys silently
    err_mark = err_seen;
    send(8'h1D);
    send(8'hAA);
    tick(2);
    check("aa_w", {31'd0, key_w}, 32'd0);
    check("aa_no_err", err_seen - err_mark, 32'd0);

    // F0 followed by E0 is a protocol error; keys untouched, back to IDLE
    err_mark = err_seen;
    send(8'h1D);
    send(8'hF0);
    send(8'hE0);
    tick();
    check("proto_w_kept", {31'd0, key_w}, 32'd1);
    check("proto_err", {31'd0, rx_err}, 32'd1);
    send(8'hF0);
    send(8'h1D);
    tick();
    check("proto_recover_w", {31'd0, key_w}, 32'd0);
    check("proto_err_count", err_seen - err_mark, 32'd1);

    // Reset in the middle of an E0 prefix
    send(8'h1D);
    send(8'hE0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_w", {31'd0, key_w}, 32'd0);
    send(8'h75);
    tick(2);
    check("rst_then_75_w", {31'd0, key_w}, 32'd0);

    // Arrow Left and letter A sharing key_a
    send(8'hE0);
    send(8'h6B);
    send(8'h1C);
    tick();
    check("arrow_a_held", {31'd0, key_a}, 32'd1);
    send(8'hF0);
    send(8'h1C);
    tick();
`ifdef KBD_ARROW_KEYS_EN
    check("arrow_a_after_letter_brk", {31'd0, key_a}, 32'd1);
`else
    check("arrow_a_after_letter_brk", {31'd0, key_a}, 32'd0);
`endif
    send(8'hE0);
    send(8'hF0);
    send(8'h6B);
    tick();
    check("arrow_a_release", {31'd0, key_a}, 32'd0);
    send(8'hE0);
    send(8'h74);
    tick();
`ifdef KBD_ARROW_KEYS_EN
    check("arrow_right_d", {31'd0, key_d}, 32'd1);
`else
    check("arrow_right_d", {31'd0, key_d}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/kbd_move_decoder.md
Name: kbd_move_decoder

Overview:
- Converts PS/2 Set-2 scancode bytes from the PS/2 byte receiver into level-held movement key signals `key_w`, `key_a` and `key_d`.
- These signals feed the player motion controller directly.
- Tracks make, break (F0) and extended (E0) prefixes with a small FSM.
- A prefix watchdog recovers from dropped bytes.

Parameters:
- CODE_W, 8'h1D, make code mapped to key_w (jump).
- CODE_A, 8'h1C, make code mapped to key_a (left).
- CODE_D, 8'h23, make code mapped to key_d (right).
- PREFIX_TIMEOUT, 65_000, clk cycles a pending prefix may wait for its next byte (10 ms at 6.5 MHz). Minimum 2.

Ports:
- clk  input  1  system clock (6.5 MHz domain).
- rst  input  1  synchronous, active-high reset.
- rx_data  input  8  received scancode byte; valid only when rx_valid=1.
- rx_valid  input  1  single-cycle strobe, one per received byte.
- key_w  output  1  1 while W is held.
- key_a  output  1  1 while A is held.
- key_d  output  1  1 while D is held.
- rx_err  output  1  single-cycle pulse on protocol error or watchdog expiry.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, watchdog counter 0. Reset asserted mid-sequence discards any pending prefix.
- All outputs are registered. A byte accepted at edge N (rx_valid=1) updates key_* and rx_err at edge N+1.
- Bytes arrive at most one per cycle. There is no backpressure; every strobe is consumed.
- FSM states:
  - IDLE: F0 -> BRK; E0 -> EXT; FF, 00 or AA -> clear all keys (pulse rx_err for FF and 00); CODE_W, CODE_A or CODE_D -> set that key; any other byte -> ignored.
  - BRK: next byte equal to a mapped code clears that key; any byte -> IDLE. A byte of F0 or E0 here is a protocol error: pulse rx_err, leave keys unchanged, go to IDLE.
  - EXT: F0 -> EXT_BRK; any other byte -> extended make handling (see Optional Feature), then IDLE.
  - EXT_BRK: any byte -> extended break handling, then IDLE.
- Typematic repeats (the same make code received again) leave the key at 1. No edge is generated.
- A break code for a key already at 0 has no effect.
- Several keys may be held simultaneously. Each bit is independent; a new make never clears another key.
- Watchdog:
  - The counter runs only in BRK, EXT and EXT_BRK.
  - It resets to 0 on every accepted byte and on entry to IDLE.
  - When it reaches PREFIX_TIMEOUT-1 with no byte: go to IDLE, pulse rx_err, and clear all keys (a possibly lost break must not leave a key stuck).
  - If rx_valid arrives in the same cycle as expiry, the byte wins: it is processed normally and there is no timeout.
- FF, 00 or AA received in any state: clear all keys and go to IDLE. rx_err pulses for FF and 00 only.
- Counter width is $clog2(PREFIX_TIMEOUT). The counter saturates; it never wraps.

Optional Feature:
- Macro: KBD_ARROW_KEYS_EN.
- When defined, extended codes map as follows: E0 75 (up) -> key_w, E0 6B (left) -> key_a, E0 74 (right) -> key_d. The matching E0 F0 xx sequence clears the key.
  - Each output is the OR of the letter source and the arrow source. These are tracked as separate internal held bits, so releasing A while Left is held keeps key_a=1.
- When undefined, all E0-prefixed sequences are consumed and ignored, and no arrow state flops exist.

Decomposition:
- Shared package `kbd_pkg`:
  - Decoder state enum `kbd_state_t` {IDLE, BRK, EXT, EXT_BRK}.
  - Constants KBD_BREAK=8'hF0, KBD_EXT=8'hE0, KBD_BAT_OK=8'hAA, KBD_ERR_FF=8'hFF, KBD_ERR_00=8'h00.
  - Arrow codes KBD_UP=8'h75, KBD_LEFT=8'h6B, KBD_RIGHT=8'h74.
- One natural sub-module: `kbd_prefix_watchdog` (counter, clear input, expiry pulse), instantiated once.
- Everything else is one FSM plus the held-bit registers.

Test Plan:
- Make/break cycle: bytes 1D, then F0 1D, 100 cycles apart -> key_w=1 from one cycle after 1D until one cycle after the second 1D. rx_err stays 0.
- Multiple keys: 1C, 23, F0 1C -> key_a and key_d both 1; after the break, key_a=0 and key_d=1. Then 23 repeated 5 times -> key_d stays 1 with no glitch.
- Watchdog: 1D, then F0, then silence for PREFIX_TIMEOUT cycles -> key_w=0 and a single rx_err pulse. A following 1D sets key_w=1 again.
- Watchdog race: F0 with the next byte 1D timed to arrive in exactly the expiry cycle -> normal break, no rx_err.
- Overrun and reset mid-sequence: 1C 23 then FF -> all keys 0, one rx_err pulse. Separately, 1D E0, then rst for 1 cycle, then 75 -> key_w=0 (or 1 only with arrows enabled after reset? no: 75 unprefixed is ignored) -> key_w=0 in both builds.
- Arrow build (KBD_ARROW_KEYS_EN defined): E0 6B, 1C, F0 1C -> key_a stays 1; then E0 F0 6B -> key_a=0. In the build without the macro, the same stimulus gives key_a=1 only between 1C and F0 1C.
